// File: rtl/sprite_plotter.sv
// Per-object pixel engine: erases the previous WIDTH x HEIGHT box, then draws it at the new position.
// Optional outline colouring of the box edge is enabled by defining SPRITE_PLOTTER_OUTLINE_EN.
module sprite_plotter #(
  parameter int unsigned WIDTH          = 4,
  parameter int unsigned HEIGHT         = 4,
  parameter logic [2:0]  BG_COLOUR      = 3'b000,
  parameter logic [2:0]  OUTLINE_COLOUR = 3'b111
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [2:0] colour_in,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CW    = 4;
  localparam int unsigned XW    = 9;
  localparam int unsigned YW    = 8;
  localparam int unsigned X_MAX = 159;
  localparam int unsigned Y_MAX = 119;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ERASE,
    S_DRAW,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  dx_q, dx_d;
  logic [CW-1:0]  dy_q, dy_d;
  logic [7:0]     new_x_q, new_x_d;
  logic [6:0]     new_y_q, new_y_d;
  logic [2:0]     new_c_q, new_c_d;
  logic [7:0]     old_x_q, old_x_d;
  logic [6:0]     old_y_q, old_y_d;
  logic           old_valid_q, old_valid_d;
  logic [7:0]     x_d;
  logic [6:0]     y_d;
  logic [2:0]     colour_d;
  logic           plot_d, busy_d, done_d;

  logic [7:0]     base_x;
  logic [6:0]     base_y;
  logic [XW-1:0]  sum_x;
  logic [YW-1:0]  sum_y;
  logic           on_screen;
  logic           row_end;
  logic           scan_last;
  logic [2:0]     draw_colour;

  // Scan geometry: sums are widened so off-screen pixels are detected, not wrapped
  assign base_x    = (state_q == S_ERASE) ? old_x_q : new_x_q;
  assign base_y    = (state_q == S_ERASE) ? old_y_q : new_y_q;
  assign sum_x     = {1'b0, base_x} + XW'(dx_q);
  assign sum_y     = {1'b0, base_y} + YW'(dy_q);
  assign on_screen = (sum_x <= XW'(X_MAX)) && (sum_y <= YW'(Y_MAX));
  assign row_end   = (dx_q == CW'(WIDTH - 1));
  assign scan_last = row_end && (dy_q == CW'(HEIGHT - 1));

`ifdef SPRITE_PLOTTER_OUTLINE_EN
  logic on_edge;
  assign on_edge     = (dx_q == '0) || row_end || (dy_q == '0) || (dy_q == CW'(HEIGHT - 1));
  assign draw_colour = on_edge ? OUTLINE_COLOUR : new_c_q;
`else
  logic unused_outline;
  assign unused_outline = ^OUTLINE_COLOUR;
  assign draw_colour    = new_c_q;
`endif

  // State, scan counters, latched coordinates and registered pixel outputs
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dx_q        <= '0;
      dy_q        <= '0;
      new_x_q     <= '0;
      new_y_q     <= '0;
      new_c_q     <= '0;
      old_x_q     <= '0;
      old_y_q     <= '0;
      old_valid_q <= 1'b0;
      x           <= '0;
      y           <= '0;
      colour      <= '0;
      plot        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      new_x_q     <= new_x_d;
      new_y_q     <= new_y_d;
      new_c_q     <= new_c_d;
      old_x_q     <= old_x_d;
      old_y_q     <= old_y_d;
      old_valid_q <= old_valid_d;
      x           <= x_d;
      y           <= y_d;
      colour      <= colour_d;
      plot        <= plot_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  // Next-state, scan stepping and next output values
  always_comb begin
    state_d     = state_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    new_x_d     = new_x_q;
    new_y_d     = new_y_q;
    new_c_d     = new_c_q;
    old_x_d     = old_x_q;
    old_y_d     = old_y_q;
    old_valid_d = old_valid_q;
    x_d         = x;
    y_d         = y;
    colour_d    = colour;
    plot_d      = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          new_x_d = x_in;
          new_y_d = y_in;
          new_c_d = colour_in;
          dx_d    = '0;
          dy_d    = '0;
          state_d = old_valid_q ? S_ERASE : S_DRAW;
        end
      end

      S_ERASE, S_DRAW: begin
        busy_d   = 1'b1;
        plot_d   = on_screen;
        x_d      = sum_x[7:0];
        y_d      = sum_y[6:0];
        colour_d = (state_q == S_ERASE) ? BG_COLOUR : draw_colour;
        if (scan_last) begin
          dx_d = '0;
          dy_d = '0;
          if (state_q == S_ERASE) begin
            state_d = S_DRAW;
          end else begin
            old_x_d     = new_x_q;
            old_y_d     = new_y_q;
            old_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end else if (row_end) begin
          dx_d = '0;
          dy_d = dy_q + CW'(1);
        end else begin
          dx_d = dx_q + CW'(1);
        end
      end

      S_DONE: begin
        busy_d  = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
